// File: rtl/sc_dot_product_scheduler.sv
// rtl/sc_dot_product_scheduler.sv - evaluation-window sequencer for a stochastic dot-product datapath
//
// Purpose:
//   Runs one evaluation window per accepted start request. The datapath is
//   held in reset while idle. It gets one flush cycle, then it runs. During the
//   run, valid result bits are counted until stream_len bits have been
//   accepted. The ones-count is then held with done until it is acknowledged.
//   The select streams come from SELECT_WIDTH 8-bit Fibonacci LFSRs
//   (x^8+x^6+x^5+x^4+1). They are reseeded in IDLE/FLUSH, so every window
//   sees the same select sequence.
//
// Optional feature (macro SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN):
//   Adds output timeout. If RUN sees 32 consecutive cycles without dp_valid,
//   the window ends with the partial count and timeout=1.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-low reset
//   start       in   request one evaluation window (ignored if stream_len==0)
//   stream_len  in   result bits to accumulate, sampled with start
//   busy        out  high in every state except IDLE
//   dp_rst      out  active-high datapath reset
//   dp_sel      out  select streams, bit i = LFSR i bit 0
//   dp_result   in   datapath stochastic output bit
//   dp_valid    in   datapath output-valid qualifier
//   count       out  ones accepted in the window
//   done        out  window complete, count valid
//   timeout     out  window ended by the idle timeout (macro builds only)
//   done_ack    in   consumer acknowledge of done

module sc_dot_product_scheduler #(
  parameter int LENGTH       = 4,
  parameter int SELECT_WIDTH = 2,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [COUNT_WIDTH-1:0]  stream_len,
  output logic                    busy,
  output logic                    dp_rst,
  output logic [SELECT_WIDTH-1:0] dp_sel,
  input  logic                    dp_result,
  input  logic                    dp_valid,
  output logic [COUNT_WIDTH-1:0]  count,
  output logic                    done,
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
  output logic                    timeout,
`endif
  input  logic                    done_ack
);

  if ((SELECT_WIDTH < 1) || (SELECT_WIDTH > 8) || (SELECT_WIDTH != $clog2(LENGTH))) begin : g_bad_params
    $error("sc_dot_product_scheduler: SELECT_WIDTH must equal clog2(LENGTH) and lie in 1..8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_dp_rst;
  logic                    r_done;
  logic [COUNT_WIDTH-1:0]  r_len;
  logic [COUNT_WIDTH-1:0]  r_acc;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic [7:0]              r_lfsr [SELECT_WIDTH];
  logic [SELECT_WIDTH-1:0] w_sel;
  logic [COUNT_WIDTH-1:0]  w_acc_next;
  logic [COUNT_WIDTH-1:0]  w_count_next;

`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
  logic [4:0]              r_idle;
  logic                    r_timeout;
  assign timeout = r_timeout;
`endif

  // LFSR i starts at a distinct one-hot seed so the select streams are decorrelated.
  function automatic logic [7:0] f_seed(input int idx);
    return 8'h01 << idx;
  endfunction

  // Shift left. Feedback taps at bits 8,6,5,4 of the polynomial map to indices 7,5,4,3.
  function automatic logic [7:0] f_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign w_acc_next   = r_acc + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  assign w_count_next = r_count + {{(COUNT_WIDTH-1){1'b0}}, dp_result};

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < SELECT_WIDTH; i++) begin
      w_sel[i] = r_lfsr[i][0];
    end
  end

  assign busy   = r_busy;
  assign dp_rst = r_dp_rst;
  assign dp_sel = w_sel;
  assign count  = r_count;
  assign done   = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_dp_rst <= 1'b1;
      r_done   <= 1'b0;
      r_len    <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      for (int i = 0; i < SELECT_WIDTH; i++) begin
        r_lfsr[i] <= f_seed(i);
      end
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
      r_idle    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          for (int i = 0; i < SELECT_WIDTH; i++) begin
            r_lfsr[i] <= f_seed(i);
          end
          // A zero-length request has nothing to count and is dropped.
          if (start && (stream_len != '0)) begin
            r_len   <= stream_len;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          for (int i = 0; i < SELECT_WIDTH; i++) begin
            r_lfsr[i] <= f_seed(i);
          end
          r_dp_rst <= 1'b0;
          r_state  <= S_RUN;
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
          r_idle   <= '0;
`endif
        end

        S_RUN: begin
          for (int i = 0; i < SELECT_WIDTH; i++) begin
            r_lfsr[i] <= f_step(r_lfsr[i]);
          end
          if (dp_valid) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
            r_idle  <= '0;
`endif
            if (w_acc_next == r_len) begin
              r_done   <= 1'b1;
              r_dp_rst <= 1'b1;
              r_state  <= S_DONE;
            end
          end
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
          // r_idle holds the number of empty cycles already seen. Reaching 31
          // means this is the 32nd empty cycle in a row.
          else if (r_idle == 5'd31) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_dp_rst  <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idle <= r_idle + 5'd1;
          end
`endif
        end

        S_DONE: begin
          if (done_ack) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_dot_product_scheduler.sv
// tb/tb_sc_dot_product_scheduler.sv - self-checking bench for sc_dot_product_scheduler
module tb_sc_dot_product_scheduler;

  localparam int LENGTH = 4;
  localparam int SW     = 2;
  localparam int CW     = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] stream_len;
  logic          busy;
  logic          dp_rst;
  logic [SW-1:0] dp_sel;
  logic          dp_result;
  logic          dp_valid;
  logic [CW-1:0] count;
  logic          done;
  logic          done_ack;
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
  logic          timeout;
`endif

  sc_dot_product_scheduler #(
    .LENGTH(LENGTH), .SELECT_WIDTH(SW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stream_len(stream_len),
    .busy(busy), .dp_rst(dp_rst), .dp_sel(dp_sel),
    .dp_result(dp_result), .dp_valid(dp_valid),
    .count(count), .done(done),
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .done_ack(done_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] len;
    logic [15:0]   bits;       // bit k is the result of the k-th valid beat
    int            lead;       // empty RUN cycles before the first valid
    int            gap;        // empty RUN cycles between later valids
    int            hold;       // cycles done_ack is withheld
    logic [CW-1:0] exp_count;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         exp_q[$];
  logic [7:0] m_lfsr [SW];
  vec_t       vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed;
    for (int i = 0; i < SW; i++) m_lfsr[i] = 8'h01 << i;
  endtask

  task automatic model_step;
    for (int i = 0; i < SW; i++)
      m_lfsr[i] = {m_lfsr[i][6:0], m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
  endtask

  function automatic logic [SW-1:0] model_sel();
    logic [SW-1:0] s;
    for (int i = 0; i < SW; i++) s[i] = m_lfsr[i][0];
    return s;
  endfunction

  // One RUN cycle: the select stream is checked against the model, then the inputs are applied.
  task automatic run_cycle(input logic v, input logic r);
    check("dp_sel_seq", dp_sel, model_sel());
    dp_valid  = v;
    dp_result = r;
    tick();
    start = 1'b0;
    model_step();
  endtask

  task automatic run_window(input vec_t v);
    int n;
    int waited;
    model_seed();
    // dp_valid/dp_result are driven high here and in FLUSH; they must be ignored.
    start = 1'b1; stream_len = v.len; dp_valid = 1'b1; dp_result = 1'b1;
    tick();
    exp_q.push_back(int'(v.exp_count));
    start = 1'b0; stream_len = ~v.len;
    check("flush_busy", busy, 1'b1);
    check("flush_dp_rst", dp_rst, 1'b1);
    tick();
    check("run_dp_rst", dp_rst, 1'b0);
    check("run_done", done, 1'b0);
    check("run_first_sel", dp_sel, {{(SW-1){1'b0}}, 1'b1});
    // Start with a different length on the first RUN cycle; it must be ignored.
    start = 1'b1; stream_len = 8'd2;
    for (int k = 0; k < int'(v.len); k++) begin
      n = (k == 0) ? v.lead : v.gap;
      for (int j = 0; j < n; j++) run_cycle(1'b0, 1'b1);
      run_cycle(1'b1, v.bits[k]);
    end
    dp_valid = 1'b0; dp_result = 1'b0;
    check("done_latency", done, 1'b1);
    waited = 0;
    while (!done && waited < 40) begin
      tick();
      waited++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_wait_timeout actual=0 expected=1");
    end
    if (exp_q.size() > 0) check("count", count, exp_q.pop_front());
    for (int h = 0; h < v.hold; h++) begin
      start = 1'b1; dp_valid = 1'b1; dp_result = 1'b1;
      tick();
      check("hold_done", done, 1'b1);
      check("hold_count", count, v.exp_count);
      check("hold_busy", busy, 1'b1);
    end
    start = 1'b0; dp_valid = 1'b0; dp_result = 1'b0;
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check("ack_done", done, 1'b0);
    check("ack_busy", busy, 1'b0);
    check("ack_dp_rst", dp_rst, 1'b1);
  endtask

  initial begin
    vecs[0] = '{len: 8'd4,  bits: 16'h000D, lead: 2, gap: 0, hold: 5, exp_count: 8'd3};
    vecs[1] = '{len: 8'd1,  bits: 16'h0001, lead: 0, gap: 0, hold: 0, exp_count: 8'd1};
    vecs[2] = '{len: 8'd1,  bits: 16'hFFFE, lead: 0, gap: 0, hold: 1, exp_count: 8'd0};
    vecs[3] = '{len: 8'd8,  bits: 16'h00FF, lead: 0, gap: 1, hold: 0, exp_count: 8'd8};
    vecs[4] = '{len: 8'd6,  bits: 16'h002A, lead: 1, gap: 2, hold: 2, exp_count: 8'd3};
    vecs[5] = '{len: 8'd5,  bits: 16'hFFE0, lead: 3, gap: 0, hold: 0, exp_count: 8'd0};
    vecs[6] = '{len: 8'd12, bits: 16'h0F0F, lead: 0, gap: 0, hold: 0, exp_count: 8'd8};

    rst = 1'b0; start = 1'b0; stream_len = '0; dp_result = 1'b0; dp_valid = 1'b0; done_ack = 1'b0;
    tick();
    tick();
    model_seed();
    check("reset_busy", busy, 1'b0);
    check("reset_dp_rst", dp_rst, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_count", count, 8'd0);
    check("reset_dp_sel", dp_sel, model_sel());
    rst = 1'b1;
    tick();

    // A zero-length request leaves the block idle.
    start = 1'b1; stream_len = 8'd0; dp_valid = 1'b1; dp_result = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("zero_len_busy", busy, 1'b0);
      check("zero_len_dp_rst", dp_rst, 1'b1);
      check("zero_len_done", done, 1'b0);
    end
    start = 1'b0; dp_valid = 1'b0; dp_result = 1'b0;

    // The windows run back to back, and each one checks the select sequence from its RUN entry.
    for (int i = 0; i < 7; i++) run_window(vecs[i]);

    // A reset after two accepted valids discards the window.
    model_seed();
    start = 1'b1; stream_len = 8'd4;
    tick();
    start = 1'b0;
    tick();
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b1, 1'b1);
    dp_valid = 1'b0;
    rst = 1'b0; done_ack = 1'b1; start = 1'b1;
    tick();
    model_seed();
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", count, 8'd0);
    check("midrst_dp_rst", dp_rst, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_dp_sel", dp_sel, model_sel());
    rst = 1'b1; done_ack = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("midrst_no_done", done, 1'b0);
    end

    // A window where dp_valid never arrives.
    model_seed();
    start = 1'b1; stream_len = 8'd4;
    tick();
    start = 1'b0;
    tick();
`ifdef SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN
    check("to_initial", timeout, 1'b0);
    for (int c = 0; c < 31; c++) run_cycle(1'b0, 1'b0);
    check("to_not_early", done, 1'b0);
    run_cycle(1'b0, 1'b0);
    check("to_done", done, 1'b1);
    check("to_flag", timeout, 1'b1);
    check("to_count", count, 8'd0);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check("to_clear", timeout, 1'b0);
    check("to_ack_busy", busy, 1'b0);
`else
    for (int c = 0; c < 40; c++) run_cycle(1'b0, 1'b0);
    check("wait_busy", busy, 1'b1);
    check("wait_no_done", done, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("wait_rst_busy", busy, 1'b0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_dot_product_scheduler.md
SC_DOT_PRODUCT_SCHEDULER -- requirements
Module: sc_dot_product_scheduler

Interface
REQ-001 Parameter LENGTH, default 4: dot-product vector length of the sequenced datapath.
REQ-002 Parameter SELECT_WIDTH, default 2: select-stream count, equal to clog2(LENGTH), range 1..8.
REQ-003 Parameter COUNT_WIDTH, default 8: width of the stream-length and ones-count fields.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  request one evaluation window.
REQ-007 stream_len  in  COUNT_WIDTH  number of datapath result bits to accumulate; sampled with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 dp_rst  out  1  active-high reset driven to the dot-product datapath.
REQ-010 dp_sel  out  SELECT_WIDTH  select streams to the datapath; bit i = LFSR i bit 0.
REQ-011 dp_result  in  1  datapath stochastic output bit.
REQ-012 dp_valid  in  1  datapath output-valid qualifier.
REQ-013 count  out  COUNT_WIDTH  number of dp_result ones accepted in the window.
REQ-014 done  out  1  window complete; count valid.
REQ-015 done_ack  in  1  consumer acknowledge of done.

Function
REQ-016 State machine SHALL have exactly four states: IDLE, FLUSH, RUN, DONE.
REQ-017 IDLE: dp_rst=1, done=0; start=1 with stream_len!=0 latches stream_len, clears count and accepted-bit counter, next state FLUSH.
REQ-018 start with stream_len=0 SHALL be ignored; state stays IDLE.
REQ-019 FLUSH: dp_rst=1 for exactly one cycle, then RUN unconditionally.
REQ-020 RUN: dp_rst=0; each cycle with dp_valid=1 increments accepted-bit counter and adds dp_result to count.
REQ-021 The cycle accepting the stream_len-th valid bit SHALL transition to DONE; done=1 starting the following cycle.
REQ-022 DONE: done=1, dp_rst=1, count held stable; done_ack=1 returns to IDLE next cycle, done deasserting with it.
REQ-023 start SHALL be ignored in FLUSH, RUN and DONE; stream_len changes after acceptance SHALL have no effect.
REQ-024 dp_valid and dp_result SHALL be ignored outside RUN.
REQ-025 count never exceeds latched stream_len, so no overflow or saturation logic exists.
REQ-026 SELECT_WIDTH independent 8-bit Fibonacci LFSRs, polynomial x^8+x^6+x^5+x^4+1; LFSR i seed = 8'h01 shifted left by i.
REQ-027 LFSRs SHALL load seeds in IDLE and FLUSH and advance once per cycle in RUN, holding in DONE.
REQ-028 The dp_sel sequence from RUN entry SHALL be identical for every window (period 255).

Reset
REQ-029 rst=0 at a rising edge SHALL force, next cycle: state IDLE, busy=0, dp_rst=1, done=0, count=0, counters 0, LFSRs seeded, dp_sel=seed bit 0.
REQ-030 Reset mid-window SHALL discard the window with no done pulse; reset has priority over start and done_ack.

Configuration
REQ-031 Macro SC_DOT_PRODUCT_SCHEDULER_TIMEOUT_EN, when defined, adds output port timeout (1 bit) and a 5-bit idle counter in RUN.
REQ-032 With it defined: 32 consecutive RUN cycles without dp_valid SHALL set timeout=1 and enter DONE with partial count; timeout clears on done_ack or reset.
REQ-033 Without it: no timeout port; RUN waits indefinitely for dp_valid.

Verification
REQ-034 stream_len=4, dp_valid from RUN cycle 3, dp_result 1,0,1,1 -> done=1 one cycle after 4th valid, count=3.
REQ-035 start with stream_len=0 -> busy stays 0, dp_rst stays 1, no done.
REQ-036 start pulsed in RUN, done_ack withheld 5 cycles -> second start ignored, done and count=value held 5 cycles, IDLE one cycle after done_ack.
REQ-037 rst=0 after 2 accepted valids -> next cycle IDLE, count=0, dp_rst=1, no done.
REQ-038 Macro defined, dp_valid never asserted -> timeout=1 and done=1 after 32 RUN cycles, count=0; macro undefined -> busy stays 1.
REQ-039 Two back-to-back windows, SELECT_WIDTH=2 -> identical dp_sel sequences from RUN entry, first RUN value dp_sel=2'b01.
